// File: rtl/alu_pipe.sv
// Pipelined integer ALU / branch-compare execute unit with a bubble-collapsing
// result pipeline that holds its head entry until the CDB grants it.
module alu_pipe #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_uop,
  input  logic              in_alt,
  input  logic              in_is_branch,
  input  logic [2:0]        in_br_fn,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [DATA_W-1:0] in_rs1,
  input  logic [DATA_W-1:0] in_rs2,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_br_taken,
  output logic              out_is_branch,
  input  logic              cdb_gnt
);

  localparam int SHW = $clog2(DATA_W);

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [TAG_W-1:0]  tag;
    logic              br_taken;
    logic              is_branch;
  } stage_t;

  logic [SHW-1:0]    shamt;
  logic [DATA_W-1:0] alu_res;
  logic              taken;
  stage_t            in_pkt;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    shamt   = in_b[SHW-1:0];
    alu_res = '0;
    unique case (in_uop)
      3'b000: alu_res = in_alt ? (in_a - in_b) : (in_a + in_b);
      3'b001: alu_res = in_a << shamt;
      3'b010: alu_res = {{(DATA_W-1){1'b0}}, $signed(in_a) < $signed(in_b)};
      3'b011: alu_res = {{(DATA_W-1){1'b0}}, in_a < in_b};
      3'b100: alu_res = in_a ^ in_b;
      3'b101: begin
        // Kept as separate branches: inside a ?: the unsigned arm would turn >>> into a logical shift.
        if (in_alt) alu_res = $signed(in_a) >>> shamt;
        else        alu_res = in_a >> shamt;
      end
      3'b110: alu_res = in_a | in_b;
      3'b111: alu_res = in_a & in_b;
    endcase

    taken = 1'b0;
    case (in_br_fn)
      3'b000:  taken = (in_rs1 == in_rs2);
      3'b001:  taken = (in_rs1 != in_rs2);
      3'b100:  taken = ($signed(in_rs1) <  $signed(in_rs2));
      3'b101:  taken = ($signed(in_rs1) >= $signed(in_rs2));
      3'b110:  taken = (in_rs1 <  in_rs2);
      3'b111:  taken = (in_rs1 >= in_rs2);
      default: taken = 1'b0;
    endcase

    in_pkt.result    = in_is_branch ? {{(DATA_W-1){1'b0}}, taken} : alu_res;
    in_pkt.tag       = in_tag;
    in_pkt.br_taken  = in_is_branch & taken;
    in_pkt.is_branch = in_is_branch;
  end

  logic [LAT-1:0] valid_q;
  stage_t         stage_q [LAT];
  logic [LAT-1:0] adv;
  logic           later_full;
  logic           accept;

  // A stage moves on when some later stage is empty (the gap collapses) or
  // every later stage is full and the head is being granted.
  always_comb begin
    adv        = '0;
    later_full = 1'b1;
    for (int k = 0; k < LAT; k++) begin
      later_full = 1'b1;
      for (int j = k + 1; j < LAT; j++) later_full = later_full & valid_q[j];
      adv[k] = valid_q[k] && (!later_full || cdb_gnt);
    end
  end

  assign in_ready = !valid_q[0] || adv[0];
  assign accept   = in_valid && in_ready && !flush;

  // NOTE: the payload registers are reset too, because the outputs must read zero while in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int k = 0; k < LAT; k++) stage_q[k] <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage read the pre-edge value of its neighbour.
      if (accept) begin
        valid_q[0] <= 1'b1;
        stage_q[0] <= in_pkt;
      end else if (adv[0]) begin
        valid_q[0] <= 1'b0;
      end
      for (int k = 1; k < LAT; k++) begin
        if (adv[k-1]) begin
          valid_q[k] <= 1'b1;
          stage_q[k] <= stage_q[k-1];
        end else if (adv[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
    end
  end

  assign out_valid     = valid_q[LAT-1];
  assign out_result    = stage_q[LAT-1].result;
  assign out_tag       = stage_q[LAT-1].tag;
  assign out_br_taken  = stage_q[LAT-1].br_taken;
  assign out_is_branch = stage_q[LAT-1].is_branch;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: a vector table on a 32-bit LAT=2 unit plus
// hand sequences for stall, flush and reset, and 64-bit LAT=1 / 32-bit LAT=4 instances.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, gnt;
  logic [2:0]  uop, brfn;
  logic        alt, isbr;
  logic [63:0] a, b, rs1, rs2;
  logic [5:0]  tag;

  logic        iv1, iv2, iv4, rdy1, rdy2, rdy4, ov1, ov2, ov4;
  logic [63:0] res1;
  logic [31:0] res2, res4;
  logic [5:0]  tg1, tg2, tg4;
  logic        tk1, tk2, tk4, isb1, isb2, isb4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_pipe #(.DATA_W(32), .TAG_W(6), .LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv2), .in_ready(rdy2),
    .in_uop(uop), .in_alt(alt), .in_is_branch(isbr), .in_br_fn(brfn),
    .in_a(a[31:0]), .in_b(b[31:0]), .in_rs1(rs1[31:0]), .in_rs2(rs2[31:0]), .in_tag(tag),
    .out_valid(ov2), .out_result(res2), .out_tag(tg2), .out_br_taken(tk2),
    .out_is_branch(isb2), .cdb_gnt(gnt));

  alu_pipe #(.DATA_W(64), .TAG_W(6), .LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv1), .in_ready(rdy1),
    .in_uop(uop), .in_alt(alt), .in_is_branch(isbr), .in_br_fn(brfn),
    .in_a(a), .in_b(b), .in_rs1(rs1), .in_rs2(rs2), .in_tag(tag),
    .out_valid(ov1), .out_result(res1), .out_tag(tg1), .out_br_taken(tk1),
    .out_is_branch(isb1), .cdb_gnt(gnt));

  alu_pipe #(.DATA_W(32), .TAG_W(6), .LAT(4)) u_dut4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(iv4), .in_ready(rdy4),
    .in_uop(uop), .in_alt(alt), .in_is_branch(isbr), .in_br_fn(brfn),
    .in_a(a[31:0]), .in_b(b[31:0]), .in_rs1(rs1[31:0]), .in_rs2(rs2[31:0]), .in_tag(tag),
    .out_valid(ov4), .out_result(res4), .out_tag(tg4), .out_br_taken(tk4),
    .out_is_branch(isb4), .cdb_gnt(gnt));

  typedef struct {
    logic [2:0]  uop;
    logic        alt;
    logic        isbr;
    logic [2:0]  brfn;
    logic [31:0] a, b, rs1, rs2;
    logic [31:0] res;
    logic        tk;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [2:0] u, input logic al, input logic br,
                              input logic [2:0] bf, input logic [31:0] va, vb, v1, v2, vr,
                              input logic vt);
    vec_t v;
    v.uop = u; v.alt = al; v.isbr = br; v.brfn = bf;
    v.a = va; v.b = vb; v.rs1 = v1; v.rs2 = v2; v.res = vr; v.tk = vt;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] u, input logic al, input logic br, input logic [2:0] bf,
                       input logic [63:0] va, vb, v1, v2, input logic [5:0] t);
    uop = u; alt = al; isbr = br; brfn = bf; a = va; b = vb; rs1 = v1; rs2 = v2; tag = t;
  endtask

  task automatic set_iv(input int d, input logic v);
    case (d)
      1:       iv1 = v;
      2:       iv2 = v;
      default: iv4 = v;
    endcase
  endtask

  function automatic logic ov_of(input int d);
    case (d)
      1:       return ov1;
      2:       return ov2;
      default: return ov4;
    endcase
  endfunction

  // Issue one packet into an idle unit and count cycles (issue cycle = 0) until out_valid.
  task automatic run_one(input int d, input logic [2:0] u, input logic al, input logic br,
                         input logic [2:0] bf, input logic [63:0] va, vb, v1, v2,
                         input logic [5:0] t, output int lat, output logic [63:0] r,
                         output logic tk, output logic isb, output logic [5:0] tg);
    drive(u, al, br, bf, va, vb, v1, v2, t);
    set_iv(d, 1'b1);
    tick();
    set_iv(d, 1'b0);
    lat = 1;
    while (!ov_of(d) && lat < 20) begin
      tick();
      lat++;
    end
    case (d)
      1:       begin r = res1;          tk = tk1; isb = isb1; tg = tg1; end
      2:       begin r = {32'b0, res2}; tk = tk2; isb = isb2; tg = tg2; end
      default: begin r = {32'b0, res4}; tk = tk4; isb = isb4; tg = tg4; end
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [63:0] r;
    logic        tk, isb;
    logic [5:0]  tg;

    // ALU vectors
    vecs.push_back(mk(3'b000, 0, 0, 0, 32'd5,        32'd7,        0, 0, 32'd12,       0));
    vecs.push_back(mk(3'b000, 1, 0, 0, 32'd5,        32'd7,        0, 0, 32'hFFFFFFFE, 0));
    vecs.push_back(mk(3'b101, 1, 0, 0, 32'h80000000, 32'd4,        0, 0, 32'hF8000000, 0));
    vecs.push_back(mk(3'b101, 0, 0, 0, 32'h80000000, 32'd4,        0, 0, 32'h08000000, 0));
    vecs.push_back(mk(3'b010, 0, 0, 0, 32'hFFFFFFFF, 32'd1,        0, 0, 32'd1,        0));
    vecs.push_back(mk(3'b011, 0, 0, 0, 32'hFFFFFFFF, 32'd1,        0, 0, 32'd0,        0));
    vecs.push_back(mk(3'b010, 0, 0, 0, 32'd1,        32'hFFFFFFFF, 0, 0, 32'd0,        0));
    vecs.push_back(mk(3'b011, 0, 0, 0, 32'd1,        32'hFFFFFFFF, 0, 0, 32'd1,        0));
    vecs.push_back(mk(3'b001, 0, 0, 0, 32'd1,        32'h25,       0, 0, 32'h20,       0));
    vecs.push_back(mk(3'b100, 0, 0, 0, 32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 32'h0FF00FF0, 0));
    vecs.push_back(mk(3'b110, 0, 0, 0, 32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 32'hFFF0FFF0, 0));
    vecs.push_back(mk(3'b111, 0, 0, 0, 32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 32'hF000F000, 0));
    vecs.push_back(mk(3'b000, 0, 0, 0, 32'hFFFFFFFF, 32'd1,        0, 0, 32'd0,        0));
    // Branch vectors: ALU operands set to values that would give a nonzero ALU result
    vecs.push_back(mk(3'b000, 0, 1, 3'b000, 32'd5, 32'd7, 32'hFFFFFFFF, 32'd1, 32'd0, 0));
    vecs.push_back(mk(3'b000, 0, 1, 3'b001, 32'd5, 32'd7, 32'hFFFFFFFF, 32'd1, 32'd1, 1));
    vecs.push_back(mk(3'b000, 0, 1, 3'b100, 32'd5, 32'd7, 32'hFFFFFFFF, 32'd1, 32'd1, 1));
    vecs.push_back(mk(3'b000, 0, 1, 3'b101, 32'd5, 32'd7, 32'hFFFFFFFF, 32'd1, 32'd0, 0));
    vecs.push_back(mk(3'b000, 0, 1, 3'b110, 32'd5, 32'd7, 32'hFFFFFFFF, 32'd1, 32'd0, 0));
    vecs.push_back(mk(3'b000, 0, 1, 3'b111, 32'd5, 32'd7, 32'hFFFFFFFF, 32'd1, 32'd1, 1));
    vecs.push_back(mk(3'b000, 0, 1, 3'b010, 32'd5, 32'd7, 32'hFFFFFFFF, 32'd1, 32'd0, 0));
    vecs.push_back(mk(3'b000, 0, 1, 3'b011, 32'd5, 32'd7, 32'd1, 32'd1, 32'd0, 0));
    vecs.push_back(mk(3'b000, 0, 1, 3'b000, 32'd5, 32'd7, 32'h1234, 32'h1234, 32'd1, 1));
    vecs.push_back(mk(3'b000, 0, 1, 3'b101, 32'd5, 32'd7, 32'h1234, 32'h1234, 32'd1, 1));
    vecs.push_back(mk(3'b000, 0, 1, 3'b100, 32'd5, 32'd7, 32'h1234, 32'h1234, 32'd0, 0));
    vecs.push_back(mk(3'b000, 0, 1, 3'b111, 32'd5, 32'd7, 32'h1234, 32'h1234, 32'd1, 1));

    rst = 1'b0; flush = 1'b0; gnt = 1'b0;
    iv1 = 1'b0; iv2 = 1'b0; iv4 = 1'b0;
    drive(3'b000, 0, 0, 0, 64'd0, 64'd0, 64'd0, 64'd0, 6'd0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", {63'b0, ov2}, 64'd0);
    check("reset out_result", {32'b0, res2}, 64'd0);
    check("reset out_tag", {58'b0, tg2}, 64'd0);
    check("reset out_br_taken", {63'b0, tk2}, 64'd0);
    check("reset out_is_branch", {63'b0, isb2}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("in_ready after reset", {63'b0, rdy2}, 64'd1);

    // Table-driven vectors, constant grant
    gnt = 1'b1;
    foreach (vecs[i]) begin
      run_one(2, vecs[i].uop, vecs[i].alt, vecs[i].isbr, vecs[i].brfn,
              {32'b0, vecs[i].a}, {32'b0, vecs[i].b}, {32'b0, vecs[i].rs1},
              {32'b0, vecs[i].rs2}, 6'(i), lat, r, tk, isb, tg);
      check($sformatf("vec%0d latency", i), 64'(lat), 64'd2);
      check($sformatf("vec%0d result", i), r, {32'b0, vecs[i].res});
      check($sformatf("vec%0d br_taken", i), {63'b0, tk}, {63'b0, vecs[i].tk});
      check($sformatf("vec%0d is_branch", i), {63'b0, isb}, {63'b0, vecs[i].isbr});
      check($sformatf("vec%0d tag", i), {58'b0, tg}, 64'(i));
    end
    tick();

    // Back-to-back ADD then SUB
    drive(3'b000, 0, 0, 0, 64'd5, 64'd7, 0, 0, 6'd40);
    iv2 = 1'b1;
    tick();
    drive(3'b000, 1, 0, 0, 64'd5, 64'd7, 0, 0, 6'd41);
    tick();
    iv2 = 1'b0;
    check("b2b first valid", {63'b0, ov2}, 64'd1);
    check("b2b first result", {32'b0, res2}, 64'd12);
    check("b2b first tag", {58'b0, tg2}, 64'd40);
    tick();
    check("b2b second valid", {63'b0, ov2}, 64'd1);
    check("b2b second result", {32'b0, res2}, 64'hFFFFFFFE);
    check("b2b second tag", {58'b0, tg2}, 64'd41);
    tick();
    check("b2b drained", {63'b0, ov2}, 64'd0);

    // Stall: no grant, three packets
    gnt = 1'b0;
    drive(3'b000, 0, 0, 0, 64'd1, 64'd2, 0, 0, 6'd10);
    iv2 = 1'b1;
    tick();
    drive(3'b000, 0, 0, 0, 64'd10, 64'd20, 0, 0, 6'd11);
    check("stall ready after 1", {63'b0, rdy2}, 64'd1);
    tick();
    drive(3'b100, 0, 0, 0, 64'hF, 64'h3, 0, 0, 6'd12);
    check("stall head valid", {63'b0, ov2}, 64'd1);
    check("stall ready full", {63'b0, rdy2}, 64'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("stall hold%0d ready", c), {63'b0, rdy2}, 64'd0);
      check($sformatf("stall hold%0d valid", c), {63'b0, ov2}, 64'd1);
      check($sformatf("stall hold%0d result", c), {32'b0, res2}, 64'd3);
      check($sformatf("stall hold%0d tag", c), {58'b0, tg2}, 64'd10);
    end
    gnt = 1'b1;
    #1;
    check("stall ready on grant", {63'b0, rdy2}, 64'd1);
    tick();
    iv2 = 1'b0;
    check("drain second result", {32'b0, res2}, 64'd30);
    check("drain second tag", {58'b0, tg2}, 64'd11);
    tick();
    check("drain third valid", {63'b0, ov2}, 64'd1);
    check("drain third result", {32'b0, res2}, 64'hC);
    check("drain third tag", {58'b0, tg2}, 64'd12);
    tick();
    check("drain empty", {63'b0, ov2}, 64'd0);

    // Flush with a half-full pipe and a packet on the input
    gnt = 1'b0;
    drive(3'b000, 0, 0, 0, 64'd1, 64'd1, 0, 0, 6'd20);
    iv2 = 1'b1;
    tick();
    drive(3'b000, 0, 0, 0, 64'd2, 64'd2, 0, 0, 6'd21);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    iv2 = 1'b0;
    check("flush out_valid", {63'b0, ov2}, 64'd0);
    gnt = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("flush stays empty%0d", c), {63'b0, ov2}, 64'd0);
    end
    run_one(2, 3'b000, 0, 0, 0, 64'd100, 64'd23, 0, 0, 6'd22, lat, r, tk, isb, tg);
    check("post-flush latency", 64'(lat), 64'd2);
    check("post-flush result", r, 64'd123);
    check("post-flush tag", {58'b0, tg}, 64'd22);
    tick();

    // Asynchronous reset while out_valid is held
    gnt = 1'b0;
    drive(3'b110, 0, 0, 0, 64'h55, 64'hAA, 0, 0, 6'd30);
    iv2 = 1'b1;
    tick();
    iv2 = 1'b0;
    tick();
    check("pre-reset out_valid", {63'b0, ov2}, 64'd1);
    check("pre-reset result", {32'b0, res2}, 64'hFF);
    #2;
    rst = 1'b0;
    #1;
    check("async reset out_valid", {63'b0, ov2}, 64'd0);
    check("async reset out_result", {32'b0, res2}, 64'd0);
    check("async reset out_tag", {58'b0, tg2}, 64'd0);
    #3;
    rst = 1'b1;
    tick();
    check("after reset out_valid", {63'b0, ov2}, 64'd0);
    check("after reset in_ready", {63'b0, rdy2}, 64'd1);

    // 64-bit, LAT=1
    gnt = 1'b1;
    run_one(1, 3'b000, 0, 0, 0, 64'h00000000FFFFFFFF, 64'd1, 0, 0, 6'd50, lat, r, tk, isb, tg);
    check("w64 add latency", 64'(lat), 64'd1);
    check("w64 add carry", r, 64'h0000000100000000);
    check("w64 add tag", {58'b0, tg}, 64'd50);
    run_one(1, 3'b101, 1, 0, 0, 64'h8000000000000000, 64'd4, 0, 0, 6'd51, lat, r, tk, isb, tg);
    check("w64 sra", r, 64'hF800000000000000);
    run_one(1, 3'b001, 0, 0, 0, 64'd1, 64'd40, 0, 0, 6'd52, lat, r, tk, isb, tg);
    check("w64 sll", r, 64'h0000010000000000);
    run_one(1, 3'b000, 0, 1, 3'b100, 64'd3, 64'd4, 64'hFFFFFFFFFFFFFFFF, 64'd1, 6'd53,
            lat, r, tk, isb, tg);
    check("w64 blt taken", {63'b0, tk}, 64'd1);
    check("w64 blt result", r, 64'd1);
    run_one(1, 3'b000, 0, 1, 3'b110, 64'd3, 64'd4, 64'hFFFFFFFFFFFFFFFF, 64'd1, 6'd54,
            lat, r, tk, isb, tg);
    check("w64 bltu taken", {63'b0, tk}, 64'd0);
    check("w64 bltu result", r, 64'd0);
    tick();

    // 32-bit, LAT=4
    run_one(4, 3'b000, 0, 0, 0, 64'd5, 64'd7, 0, 0, 6'd60, lat, r, tk, isb, tg);
    check("lat4 latency", 64'(lat), 64'd4);
    check("lat4 result", r, 64'd12);
    check("lat4 tag", {58'b0, tg}, 64'd60);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, pipelined integer ALU and branch-compare execute unit. It replaces the single-stage ALU in the execute cluster.
- Accepts one issued packet per cycle through a valid/ready handshake and computes in the first stage.
- Carries results through LAT bubble-collapsing pipeline registers and presents them to the CDB arbiter. The output is held until granted.
- Supports flush, configurable data and tag width, and correct signed/unsigned branch comparisons.

Parameters:
- DATA_W, 32, operand/result width; power of two, at least 8.
- TAG_W, 6, destination physical-register tag width.
- LAT, 2, number of pipeline stages from accept to out_valid; legal range 1..4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline kill.
- in_valid  in  1  issue packet valid.
- in_ready  out  1  unit can accept this cycle.
- in_uop  in  3  ALU funct3.
- in_alt  in  1  funct7 bit5 (SUB/SRA select).
- in_is_branch  in  1  packet is a conditional branch.
- in_br_fn  in  3  branch funct3.
- in_a  in  DATA_W  ALU operand A.
- in_b  in  DATA_W  ALU operand B (rs2 or immediate).
- in_rs1  in  DATA_W  branch operand 1.
- in_rs2  in  DATA_W  branch operand 2.
- in_tag  in  TAG_W  destination tag.
- out_valid  out  1  result valid, requesting the CDB.
- out_result  out  DATA_W  result.
- out_tag  out  TAG_W  destination tag.
- out_br_taken  out  1  branch outcome.
- out_is_branch  out  1  result belongs to a branch.
- cdb_gnt  in  1  CDB grant for the current out_valid.

Behaviour:
- Reset (rst low, asynchronous):
  - All stage valid bits clear.
  - out_valid, out_result, out_tag, out_br_taken and out_is_branch are 0.
  - in_ready is 1 once reset is released.
- Accept rule: a packet is taken when in_valid && in_ready at the clock edge.
- Compute: the whole result is computed combinationally from the in_* inputs and captured into stage 0.
  - Shift amount is b[$clog2(DATA_W)-1:0].
- ALU funct3 encoding:
  - 000: in_alt ? a-b : a+b, modulo 2^DATA_W.
  - 001: SLL.
  - 010: signed a<b, zero-extended.
  - 011: unsigned a<b, zero-extended.
  - 100: XOR.
  - 101: in_alt ? arithmetic right shift : logical right shift.
  - 110: OR.
  - 111: AND.
- Branch packets (in_is_branch=1):
  - taken encoding: 000 BEQ, 001 BNE, 100 BLT signed, 101 BGE signed, 110 BLTU unsigned, 111 BGEU unsigned; 010 and 011 give not taken.
  - out_result = {(DATA_W-1) zeros, taken}.
  - out_br_taken = taken.
  - ALU path output is ignored.
- Non-branch packets: out_br_taken = 0, out_is_branch = 0.
- Pipeline: stages s0..s(LAT-1); s(LAT-1) drives the out_* ports.
  - Stage k advances into k+1 when k is valid and k+1 is empty or advancing.
  - Last stage advances (empties) when out_valid && cdb_gnt.
  - in_ready = !s0.valid || s0 advancing. It is combinational from cdb_gnt and the valid bits; there is no combinational path from in_valid.
  - Bubbles collapse: a stalled output does not block earlier stages from filling gaps.
- Latency:
  - An accepted packet with an empty pipe and constant grant shows out_valid exactly LAT cycles after the accept edge.
  - Sustained throughput is 1 packet/cycle when cdb_gnt is held high.
- Output hold: while out_valid && !cdb_gnt, all out_* ports are stable. Packets never reorder, duplicate or drop except on flush.
- cdb_gnt while out_valid=0 is ignored.
- flush=1 at an edge:
  - All valid bits clear and out_valid=0 the next cycle.
  - A packet presented in that cycle is dropped; in_ready may read 1 but the accept is discarded.
  - flush has priority over both accept and grant.
- Full pipe with no grant: in_ready=0 and the pipe holds its contents.
- Full pipe with grant in the same cycle as in_valid: the new packet is accepted and all stages shift.
- Reset asserted mid-stall: all packets are discarded asynchronously.

Test Plan:
1. LAT=2, cdb_gnt=1; issue ADD a=5,b=7, then SUB with in_alt=1, a=5,b=7 -> out_result 12 at cycle 2, then 0xFFFFFFFE at cycle 3; tags preserved in order.
2. SRA a=0x80000000,b=4 -> 0xF8000000; SRL gives 0x08000000. SLT a=0xFFFFFFFF,b=1 -> 1; SLTU gives 0.
3. Branches with rs1=0xFFFFFFFF, rs2=1: BLT not taken... correction, BLT taken=1, BLTU 0, BGE 0, BGEU 1, BEQ 0, BNE 1. br_fn=010 -> taken=0. For every case out_result[DATA_W-1:1]=0.
4. Hold cdb_gnt=0 and issue 3 packets with LAT=2 -> pipe fills, in_ready=0 after 2 accepts, out_* stable. Then raise cdb_gnt -> the three results drain in issue order, one per cycle.
5. Half-full pipe plus an in_valid packet; assert flush for one cycle -> out_valid=0 next cycle, no stale result ever appears, next accepted packet emerges after LAT cycles.
6. Assert rst low asynchronously between clock edges while out_valid=1 -> out_valid drops immediately; repeat test 1 with DATA_W=64, LAT=1, LAT=4 -> latencies 1 and 4, 64-bit ADD carry correct.
